uart_receiver: RTL

//  Asynchronous serial receiver, 8N1, LSB first; receive-side counterpart of the UARTTransmitter.

---
 rtl/uart_receiver_pkg.sv | 14 +
 rtl/uart_receiver_if.sv | 11 +
 rtl/uart_receiver_sync_2ff.sv | 15 +
 rtl/uart_receiver.sv | 107 ++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// uart_receiver_pkg: frame constants and FSM encoding shared by the UART receive and transmit sides.
package uart_receiver_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_e;
   localparam int UART_DATA_BITS = 8;
   function automatic int half_bit(input int clocks_per_bit);
      return (clocks_per_bit - 1) / 2;
   endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus received-byte outputs of the UART receiver.
interface uart_receiver_if;
   import uart_receiver_pkg::*;
   logic                      serial_rx;
   logic                      received_valid;
   logic [UART_DATA_BITS-1:0] received_data;
   logic                      framing_error;
   logic                      active;
   modport master (input serial_rx, output received_valid, received_data, framing_error, active);
   modport slave (output serial_rx, input received_valid, received_data, framing_error, active);
endinterface

// File: rtl/uart_receiver_sync_2ff.sv
// uart_receiver_sync_2ff: two-flop synchroniser for asynchronous inputs with a selectable reset value.
module uart_receiver_sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;
   always_ff @(posedge clock) begin
      ff_q <= reset ? {2{RESET_VALUE}} : {ff_q[0], d_i};
   end
   assign q_o = ff_q[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first serial receiver with midpoint sampling and stop-bit framing check.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 5
) (
   input  logic clock,
   input  logic reset,
   uart_receiver_if.master rx
);
   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] HALF_C = CW'(half_bit(CLOCKS_PER_BIT));
   localparam logic [CW-1:0] LAST_C = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT_C = BW'(UART_DATA_BITS - 1);

   state_e                    state_q, state_d;
   logic [CW-1:0]             clk_q, clk_d;
   logic [BW-1:0]             bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q;
   logic                      done_q, done_d, ok_q, valid_q, ferr_q;
   logic                      rx_s;
   logic                      tick;

   uart_receiver_sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (rx.serial_rx),
      .q_o   (rx_s)
   );

   assign tick = clk_q == LAST_C;

   always_comb begin
      state_d = state_q;
      clk_d   = clk_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = rx_s ? IDLE : START;
            clk_d   = '0;
         end
         START: begin
            if (clk_q == HALF_C) begin
               state_d = rx_s ? IDLE : DATA;
               clk_d   = '0;
               bit_d   = '0;
            end else begin
               clk_d = clk_q + 1'b1;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               clk_d   = '0;
               bit_d   = bit_q + 1'b1;
               state_d = bit_q == LAST_BIT_C ? STOP : DATA;
            end else begin
               clk_d = clk_q + 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               done_d  = 1'b1;
               clk_d   = '0;
               state_d = rx_s ? IDLE : BREAK;
            end else begin
               clk_d = clk_q + 1'b1;
            end
         end
         BREAK:   state_d = rx_s ? IDLE : BREAK;
         default: state_d = IDLE;
      endcase
   end

   // stop-bit verdict is captured with the sample, then published one cycle later
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         clk_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         clk_q   <= clk_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ok_q    <= rx_s;
         valid_q <= done_q & ok_q;
         ferr_q  <= done_q & ~ok_q;
         data_q  <= (done_q & ok_q) ? shift_q : data_q;
      end
   end

   assign rx.received_valid = valid_q;
   assign rx.received_data  = data_q;
   assign rx.framing_error  = ferr_q;
   assign rx.active         = state_q != IDLE;
endmodule
